// File: rtl/afifo_wr_burst_split.sv
// afifo_wr_burst_split
// Write-domain front end for the 77-bit, 2-deep asynchronous FIFO. Accepts a
// burst command plus a write-data beat channel and expands each burst into
// single-beat FIFO entries, honouring fifo_wr_full.
//
// Optional feature macro: AFIFO_WR_STALL_CNT_EN (builds the stall counter;
// when undefined stall_cnt is tied to zero).
//
// Ports
//   wr_clk, wr_reset_n       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      burst command handshake
//   cmd_addr/write/len/id    burst start address, direction, beats-1, id
//   wd_valid/wd_ready        write-data beat handshake
//   wd_data/strb/last        write-data beat payload
//   fifo_wr_en/wr_data       FIFO write port
//   fifo_wr_full             FIFO full (registered-full mode)
//   busy                     burst in progress
//   err_len                  sticky wd_last / length mismatch
//   stall_cnt                saturating full-stall cycle counter
//
// Entry format: [76:69] id, [68] write, [67:64] strb, [63:32] data, [31:0] addr
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_BURST | issuing beats until beat_cnt == len is pushed

module afifo_wr_burst_split #(
    parameter int LEN_W      = 4,
    parameter int BOUND_BITS = 12,
    parameter int ADDR_INC   = 4
) (
    input  logic              wr_clk,
    input  logic              wr_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_addr,
    input  logic              cmd_write,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        cmd_id,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [31:0]       wd_data,
    input  logic [3:0]        wd_strb,
    input  logic              wd_last,
    output logic              fifo_wr_en,
    output logic [76:0]       fifo_wr_data,
    input  logic              fifo_wr_full,
    output logic              busy,
    output logic              err_len,
    output logic [15:0]       stall_cnt
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_BURST = 1'b1;

    logic             r_state;
    logic [31:0]      r_addr;
    logic             r_write;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_id;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_err_len;

    logic             w_burst;
    logic             w_push;
    logic             w_last_beat;
    logic [BOUND_BITS-1:0] w_addr_lo_next;

    assign w_burst     = (r_state == S_BURST);
    assign w_last_beat = (r_beat_cnt == r_len);

    // Push decided combinationally from the live full flag so a full that
    // rises this cycle is never overrun.
    assign w_push      = w_burst & ~fifo_wr_full & (r_write ? wd_valid : 1'b1);

    assign cmd_ready   = ~w_burst;
    assign wd_ready    = w_burst & r_write & ~fifo_wr_full;
    assign fifo_wr_en  = w_push;
    assign busy        = w_burst;
    assign err_len     = r_err_len;

    // Read beats carry zero data and strobes.
    assign fifo_wr_data = {r_id, r_write,
                           r_write ? wd_strb : 4'h0,
                           r_write ? wd_data : 32'h0,
                           r_addr};

    // Only the low BOUND_BITS advance; the upper address bits stay put so a
    // burst wraps inside its 4 KB region.
    assign w_addr_lo_next = r_addr[BOUND_BITS-1:0] + BOUND_BITS'(ADDR_INC);

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_len      <= '0;
            r_id       <= '0;
            r_beat_cnt <= '0;
            r_err_len  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr     <= cmd_addr;
                        r_write    <= cmd_write;
                        r_len      <= cmd_len;
                        r_id       <= cmd_id;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_push) begin
                        r_addr     <= {r_addr[31:BOUND_BITS], w_addr_lo_next};
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        // wd_last is only checked, never used to end a burst.
                        if (r_write && (wd_last != w_last_beat))
                            r_err_len <= 1'b1;
                        if (w_last_beat)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AFIFO_WR_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stalled;

    assign w_stalled = w_burst & fifo_wr_full & (~r_write | wd_valid);

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n)
            r_stall_cnt <= '0;
        else if (w_stalled && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_afifo_wr_burst_split.sv
// tb_afifo_wr_burst_split
// Directed and randomized bursts against a beat-list reference model: each
// burst's expected entries are derived from the command (address list by
// modular arithmetic, data from the beats the bench drives).

module tb_afifo_wr_burst_split;

    logic        wr_clk;
    logic        wr_reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [3:0]  cmd_len;
    logic [7:0]  cmd_id;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        wd_last;
    logic        fifo_wr_en;
    logic [76:0] fifo_wr_data;
    logic        fifo_wr_full;
    logic        busy;
    logic        err_len;
    logic [15:0] stall_cnt;

    afifo_wr_burst_split dut (
        .wr_clk       (wr_clk),
        .wr_reset_n   (wr_reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_write    (cmd_write),
        .cmd_len      (cmd_len),
        .cmd_id       (cmd_id),
        .wd_valid     (wd_valid),
        .wd_ready     (wd_ready),
        .wd_data      (wd_data),
        .wd_strb      (wd_strb),
        .wd_last      (wd_last),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_full (fifo_wr_full),
        .busy         (busy),
        .err_len      (err_len),
        .stall_cnt    (stall_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        model_err;
    int unsigned model_stall;
    logic [31:0] tb_data [16];
    logic [3:0]  tb_strb [16];

    task automatic chk(input string tag, input logic [76:0] got, input logic [76:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i);
        int lo;
        lo = (int'(base[11:0]) + 4 * i) % 4096;
        return {base[31:12], 12'(lo)};
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef AFIFO_WR_STALL_CNT_EN
        return 16'(model_stall);
`else
        return 16'd0;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_wd_ready"}, wd_ready, 1'b0);
        chk({tag, "_wr_en"}, fifo_wr_en, 1'b0);
        chk({tag, "_wr_data"}, fifo_wr_data, 77'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_len"}, err_len, 1'b0);
        chk({tag, "_stall"}, stall_cnt, 16'd0);
    endtask

    task automatic fill_beats(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            tb_data[i] = rnd ? $urandom : 32'hA5000000 + i;
            tb_strb[i] = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
        end
    endtask

    // full_mode: 0 never full, 1 random full, 2 full for 5 cycles at beat 1.
    // abort_at: beat index at which reset is asserted (-1 = none).
    task automatic run_burst(input logic [31:0] addr, input logic wr, input logic [3:0] len,
                             input logic [7:0] id, input int last_pos, input int full_mode,
                             input bit valid_rand, input int abort_at);
        int   beat = 0;
        int   cyc  = 0;
        int   stall_left = 5;
        logic en;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_len   = len;
        cmd_id    = id;
        @(negedge wr_clk);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        @(posedge wr_clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_write = ~wr;
        cmd_len   = 4'($urandom_range(0, 15));
        cmd_id    = 8'($urandom_range(0, 255));
        while (beat <= int'(len)) begin
            if (beat == abort_at) begin
                wr_reset_n = 1'b0;
                wd_valid   = 1'b0;
                #2;
                check_reset_values("abort");
                model_err   = 1'b0;
                model_stall = 0;
                #4;
                wr_reset_n = 1'b1;
                @(posedge wr_clk); #1;
                return;
            end
            if (cyc > 300) begin
                chk("timeout", 1'b1, 1'b0);
                break;
            end
            case (full_mode)
                1:       fifo_wr_full = ($urandom_range(0, 3) == 0);
                2:       fifo_wr_full = (beat == 1) && (stall_left > 0);
                default: fifo_wr_full = 1'b0;
            endcase
            wd_valid = valid_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            wd_data  = tb_data[beat];
            wd_strb  = tb_strb[beat];
            wd_last  = (beat == last_pos);
            @(negedge wr_clk);
            en = !fifo_wr_full && (wr ? wd_valid : 1'b1);
            chk("wr_en", fifo_wr_en, en);
            chk("wd_ready", wd_ready, wr && !fifo_wr_full);
            chk("busy", busy, 1'b1);
            chk("cmd_ready", cmd_ready, 1'b0);
            chk("err_len", err_len, model_err);
            if (en) begin
                chk("entry", fifo_wr_data,
                    {id, wr, wr ? tb_strb[beat] : 4'h0, wr ? tb_data[beat] : 32'h0,
                     beat_addr(addr, beat)});
                if (wr && ((beat == last_pos) != (beat == int'(len))))
                    model_err = 1'b1;
            end
            if (fifo_wr_full && (!wr || wd_valid) && model_stall != 65535)
                model_stall++;
            if (fifo_wr_full && full_mode == 2) stall_left--;
            @(posedge wr_clk); #1;
            if (en) beat++;
            cyc++;
        end
        // Stray write data while idle must be held off.
        wd_valid     = 1'b1;
        wd_last      = 1'b0;
        fifo_wr_full = 1'b0;
        @(negedge wr_clk);
        chk("end_busy", busy, 1'b0);
        chk("end_cmd_ready", cmd_ready, 1'b1);
        chk("end_wd_ready", wd_ready, 1'b0);
        chk("end_wr_en", fifo_wr_en, 1'b0);
        chk("end_err_len", err_len, model_err);
        chk("end_stall", stall_cnt, exp_stall());
        @(posedge wr_clk); #1;
        wd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  l;
        int          lp;
        wr_reset_n   = 1'b0;
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_write    = 1'b0;
        cmd_len      = '0;
        cmd_id       = '0;
        wd_valid     = 1'b0;
        wd_data      = '0;
        wd_strb      = '0;
        wd_last      = 1'b0;
        fifo_wr_full = 1'b0;
        model_err    = 1'b0;
        model_stall  = 0;
        #12;
        check_reset_values("reset");
        #11;
        wr_reset_n = 1'b1;
        @(posedge wr_clk); #1;

        fill_beats(1'b0);
        run_burst(32'h00001000, 1'b0, 4'd3, 8'h5A, 3, 0, 1'b0, -1);

        fill_beats(1'b0);
        tb_data[0] = 32'hDEADBEEF;
        tb_data[1] = 32'h12345678;
        run_burst(32'h00000040, 1'b1, 4'd1, 8'h11, 1, 0, 1'b0, -1);

        fill_beats(1'b1);
        run_burst(32'h00000100, 1'b1, 4'd3, 8'h22, 3, 2, 1'b0, -1);

        run_burst(32'h00002FF8, 1'b0, 4'd3, 8'h33, 3, 0, 1'b0, -1);

        fill_beats(1'b1);
        run_burst(32'h00000200, 1'b1, 4'd2, 8'h44, 0, 0, 1'b0, -1);
        run_burst(32'h00000300, 1'b1, 4'd1, 8'h45, 1, 0, 1'b0, -1);
        run_burst(32'h00000400, 1'b0, 4'd1, 8'h46, 1, 0, 1'b0, -1);

        run_burst(32'h00005000, 1'b1, 4'd7, 8'h55, 7, 0, 1'b0, 2);
        run_burst(32'h00006FFC, 1'b1, 4'd2, 8'h56, 2, 0, 1'b0, -1);

        for (int t = 0; t < 60; t++) begin
            fill_beats(1'b1);
            a = $urandom;
            a[1:0] = 2'b00;
            l = 4'($urandom_range(0, 15));
            lp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'(l);
            run_burst(a, 1'($urandom_range(0, 1)), l, 8'($urandom_range(0, 255)), lp, 1,
                      1'b1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
